// File: rtl/driver_link_decoder_if.sv
// Link-side bundle for the TLC5957 link decoder: driver pins in, decoded results out.
interface driver_link_decoder_if #(
  parameter int unsigned SR_WIDTH   = 48,
  parameter int unsigned GCLK_CNT_W = 11
);
  logic                  link_sclk;
  logic                  link_gclk;
  logic                  link_lat;
  logic                  link_sin;
  logic                  link_sout;
  logic                  cmd_valid;
  logic [3:0]            cmd_code;
  logic                  cmd_error;
  logic [SR_WIDTH-1:0]   fc_reg;
  logic                  fc_write_en;
  logic [SR_WIDTH-1:0]   gs_word;
  logic                  gs_word_valid;
  logic [3:0]            gs_word_index;
  logic                  latgs_pulse;
  logic [GCLK_CNT_W-1:0] gclk_per_segment;

  modport master (
    output link_sclk, link_gclk, link_lat, link_sin,
    input  link_sout, cmd_valid, cmd_code, cmd_error, fc_reg, fc_write_en,
           gs_word, gs_word_valid, gs_word_index, latgs_pulse, gclk_per_segment
  );

  modport slave (
    input  link_sclk, link_gclk, link_lat, link_sin,
    output link_sout, cmd_valid, cmd_code, cmd_error, fc_reg, fc_write_en,
           gs_word, gs_word_valid, gs_word_index, latgs_pulse, gclk_per_segment
  );
endinterface

// File: rtl/driver_link_decoder.sv
// Oversampling receiver for the TLC5957 link: decodes LAT-width commands, rebuilds
// FC/GS words, counts GCLK per segment and regenerates SOUT from the shift register.
module driver_link_decoder #(
  parameter int unsigned SR_WIDTH   = 48,
  parameter int unsigned MAX_WORDS  = 16,
  parameter int unsigned GCLK_CNT_W = 11
) (
  input logic                  clk,
  input logic                  rst,
  driver_link_decoder_if.slave link
);
  localparam int unsigned CODE_W = 4;
  localparam int unsigned IDXO_W = 4;
  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);

  localparam logic [CODE_W-1:0] CMD_WRTGS   = CODE_W'(1);
  localparam logic [CODE_W-1:0] CMD_LATGS   = CODE_W'(3);
  localparam logic [CODE_W-1:0] CMD_WRTFC   = CODE_W'(5);
  localparam logic [CODE_W-1:0] CMD_READFC  = CODE_W'(11);
  localparam logic [CODE_W-1:0] CMD_FCWRTEN = CODE_W'(15);

  logic sclk_q, gclk_q, lat_q, sin_q;
  logic sclk_prev_q, gclk_prev_q, lat_prev_q;

  logic [SR_WIDTH-1:0]   sr_q, sr_d;
  logic [CODE_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [GCLK_CNT_W-1:0] gclk_cnt_q, gclk_cnt_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CODE_W-1:0]     cmd_code_q, cmd_code_d;
  logic                  cmd_error_q, cmd_error_d;
  logic [SR_WIDTH-1:0]   fc_reg_q, fc_reg_d;
  logic                  fc_we_q, fc_we_d;
  logic [SR_WIDTH-1:0]   gs_word_q, gs_word_d;
  logic                  gs_valid_q, gs_valid_d;
  logic [IDXO_W-1:0]     gs_index_q, gs_index_d;
  logic                  latgs_q, latgs_d;
  logic [GCLK_CNT_W-1:0] gps_q, gps_d;

  logic sclk_rise, gclk_rise, lat_fall;

  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign gclk_rise = gclk_q & ~gclk_prev_q;
  assign lat_fall  = lat_prev_q & ~lat_q;

  // Input sampling, edge history and all architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= 1'b0;
      gclk_q      <= 1'b0;
      lat_q       <= 1'b0;
      sin_q       <= 1'b0;
      sclk_prev_q <= 1'b0;
      gclk_prev_q <= 1'b0;
      lat_prev_q  <= 1'b0;
      sr_q        <= '0;
      lat_cnt_q   <= '0;
      word_idx_q  <= '0;
      gclk_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_error_q <= 1'b0;
      fc_reg_q    <= '0;
      fc_we_q     <= 1'b0;
      gs_word_q   <= '0;
      gs_valid_q  <= 1'b0;
      gs_index_q  <= '0;
      latgs_q     <= 1'b0;
      gps_q       <= '0;
    end else begin
      sclk_q      <= link.link_sclk;
      gclk_q      <= link.link_gclk;
      lat_q       <= link.link_lat;
      sin_q       <= link.link_sin;
      sclk_prev_q <= sclk_q;
      gclk_prev_q <= gclk_q;
      lat_prev_q  <= lat_q;
      sr_q        <= sr_d;
      lat_cnt_q   <= lat_cnt_d;
      word_idx_q  <= word_idx_d;
      gclk_cnt_q  <= gclk_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_error_q <= cmd_error_d;
      fc_reg_q    <= fc_reg_d;
      fc_we_q     <= fc_we_d;
      gs_word_q   <= gs_word_d;
      gs_valid_q  <= gs_valid_d;
      gs_index_q  <= gs_index_d;
      latgs_q     <= latgs_d;
      gps_q       <= gps_d;
    end
  end

  // Shift, count and decode; decode sees the post-shift register value.
  always_comb begin
    sr_d        = sr_q;
    lat_cnt_d   = lat_cnt_q;
    word_idx_d  = word_idx_q;
    gclk_cnt_d  = gclk_cnt_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_error_d = 1'b0;
    fc_reg_d    = fc_reg_q;
    fc_we_d     = fc_we_q;
    gs_word_d   = gs_word_q;
    gs_valid_d  = 1'b0;
    gs_index_d  = gs_index_q;
    latgs_d     = 1'b0;
    gps_d       = gps_q;

    if (sclk_rise) begin
      sr_d = {sr_q[SR_WIDTH-2:0], sin_q};
      if (lat_q && (lat_cnt_q != '1)) begin
        lat_cnt_d = lat_cnt_q + CODE_W'(1);
      end
    end

    if (gclk_rise && (gclk_cnt_q != '1)) begin
      gclk_cnt_d = gclk_cnt_q + GCLK_CNT_W'(1);
    end

    if (lat_fall) begin
      lat_cnt_d = '0;
      if (lat_cnt_q != '0) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = lat_cnt_q;
        case (lat_cnt_q)
          CMD_WRTGS, CMD_LATGS: begin
            if (word_idx_q == IDX_W'(MAX_WORDS)) begin
              cmd_error_d = 1'b1;
            end else begin
              gs_word_d  = sr_d;
              gs_valid_d = 1'b1;
              gs_index_d = IDXO_W'(word_idx_q);
              word_idx_d = word_idx_q + IDX_W'(1);
            end
            if (lat_cnt_q == CMD_LATGS) begin
              latgs_d    = 1'b1;
              gps_d      = gclk_cnt_d;
              gclk_cnt_d = '0;
              word_idx_d = '0;
            end
          end
          CMD_WRTFC: begin
            if (fc_we_q) begin
              fc_reg_d = sr_d;
              fc_we_d  = 1'b0;
            end
          end
          CMD_READFC:  sr_d = fc_reg_q;
          CMD_FCWRTEN: fc_we_d = 1'b1;
          default:     cmd_error_d = 1'b1;
        endcase
      end
    end
  end

  assign link.link_sout        = sr_q[SR_WIDTH-1];
  assign link.cmd_valid        = cmd_valid_q;
  assign link.cmd_code         = cmd_code_q;
  assign link.cmd_error        = cmd_error_q;
  assign link.fc_reg           = fc_reg_q;
  assign link.fc_write_en      = fc_we_q;
  assign link.gs_word          = gs_word_q;
  assign link.gs_word_valid    = gs_valid_q;
  assign link.gs_word_index    = gs_index_q;
  assign link.latgs_pulse      = latgs_q;
  assign link.gclk_per_segment = gps_q;
endmodule
